rib_arb_xbar: RTL

- Parametrised successor to the fixed 2-master/5-slave RIB interconnect.
- Connects NUM_M bus masters (CPU, uart_debug, future DMA) to NUM_S memory-mapped slaves through one shared bus path.
- Arbitration is selectable: round-robin or fixed priority. A lock counter bounds how long one master can hold the bus. Each master gets its own hold flag. Accesses to unmapped addresses are flagged as errors.
- Sits between the masters and the rom/ram/uart/gpio/timer slaves in the SoC top.

---
 rtl/rib_arb_xbar_if.sv | 39 +++
 rtl/rib_arb_xbar.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rib_arb_xbar_if.sv
// Bus bundle between the RIB masters, the arbiter/crossbar and the slaves.
// master: driven by masters and slave read data; slave: the crossbar view.
interface rib_arb_xbar_if #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [NUM_M-1:0]        m_wr_req_i;
  logic [NUM_M-1:0]        m_wr_en_i;
  logic [NUM_M*ADDR_W-1:0] m_wr_addr_i;
  logic [NUM_M*DATA_W-1:0] m_wr_data_i;
  logic [NUM_M-1:0]        m_rd_req_i;
  logic [NUM_M*ADDR_W-1:0] m_rd_addr_i;
  logic [NUM_M*DATA_W-1:0] m_rd_data_o;
  logic [NUM_M-1:0]        m_hold_o;
  logic [NUM_S-1:0]        s_wr_en_o;
  logic [ADDR_W-1:0]       s_wr_addr_o;
  logic [DATA_W-1:0]       s_wr_data_o;
  logic [ADDR_W-1:0]       s_rd_addr_o;
  logic [NUM_S*DATA_W-1:0] s_rd_data_i;
  logic [NUM_M-1:0]        gnt_o;
  logic                    err_o;
  logic [ADDR_W-1:0]       err_addr_o;

  modport master (
    output m_wr_req_i, m_wr_en_i, m_wr_addr_i, m_wr_data_i,
    output m_rd_req_i, m_rd_addr_i, s_rd_data_i,
    input  m_rd_data_o, m_hold_o, s_wr_en_o, s_wr_addr_o,
    input  s_wr_data_o, s_rd_addr_o, gnt_o, err_o, err_addr_o
  );

  modport slave (
    input  m_wr_req_i, m_wr_en_i, m_wr_addr_i, m_wr_data_i,
    input  m_rd_req_i, m_rd_addr_i, s_rd_data_i,
    output m_rd_data_o, m_hold_o, s_wr_en_o, s_wr_addr_o,
    output s_wr_data_o, s_rd_addr_o, gnt_o, err_o, err_addr_o
  );
endinterface

// File: rtl/rib_arb_xbar.sv
// NUM_M-master / NUM_S-slave RIB arbiter and shared-path crossbar.
// Ports: clk, rst_n (async low), bus (rib_arb_xbar_if.slave).
module rib_arb_xbar #(
  parameter int NUM_M    = 3,
  parameter int NUM_S    = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SEL_LSB  = 28,
  parameter int ARB_MODE = 0,
  parameter int LOCK_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rib_arb_xbar_if.slave bus
);
  localparam int IW = $clog2(NUM_M);
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [IW-1:0]     owner, rr_ptr, gidx;
  logic              owner_valid, gvld;
  logic [LW-1:0]     lock_cnt;
  logic [NUM_M-1:0]  req, cand, gnt, oh_own;
  logic              others, lock_ok, keep, expired;
  int                rr_idx;
  logic              wr_req_g, wr_en_g, rd_req_g;
  logic [ADDR_W-1:0] wa, ra;
  logic [DATA_W-1:0] wd, rdat;
  logic [NUM_M*DATA_W-1:0] rdo;
  logic [NUM_S-1:0]  wen;
  logic [3:0]        wsel, rsel;
  logic              w_map, r_map, w_err, r_err;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Requests are masked in reset so strobes and grants drop at once.
  always_comb begin
    req     = rst_n ? (bus.m_wr_req_i | bus.m_rd_req_i) : '0;
    oh_own  = NUM_M'(1) << owner;
    others  = |(req & ~oh_own);
    lock_ok = lock_cnt < LW'(LOCK_MAX - 1);
    keep    = owner_valid & req[owner] & (~others | lock_ok);
    expired = owner_valid & req[owner] & others & ~lock_ok;
    // An owner whose lock ran out sits this round out.
    cand    = expired ? (req & ~oh_own) : req;
  end

  always_comb begin
    gidx   = '0;
    gvld   = 1'b0;
    rr_idx = 0;
    if (keep) begin
      gidx = owner;
      gvld = 1'b1;
    end else if (ARB_MODE == 1) begin
      for (int i = 0; i < NUM_M; i++)
        if (cand[i]) begin
          gidx = IW'(i);
          gvld = 1'b1;
        end
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= NUM_M) rr_idx = rr_idx - NUM_M;
        if (!gvld && cand[rr_idx]) begin
          gidx = IW'(rr_idx);
          gvld = 1'b1;
        end
      end
    end
    gnt = gvld ? (NUM_M'(1) << gidx) : '0;
  end

  always_comb begin
    wr_req_g = gvld & bus.m_wr_req_i[gidx];
    wr_en_g  = gvld & bus.m_wr_en_i[gidx];
    rd_req_g = gvld & bus.m_rd_req_i[gidx];
    wa = gvld ? bus.m_wr_addr_i[gidx*ADDR_W +: ADDR_W] : '0;
    ra = gvld ? bus.m_rd_addr_i[gidx*ADDR_W +: ADDR_W] : '0;
    wd = gvld ? bus.m_wr_data_i[gidx*DATA_W +: DATA_W] : '0;
    wsel  = wa[SEL_LSB +: 4];
    rsel  = ra[SEL_LSB +: 4];
    w_map = 1'b0;
    wen   = '0;
    for (int j = 0; j < NUM_S; j++)
      if (wsel == 4'(j)) begin
        w_map  = 1'b1;
        wen[j] = wr_req_g & wr_en_g;
      end
    r_map = 1'b0;
    rdat  = '0;
    for (int j = 0; j < NUM_S; j++)
      if (rsel == 4'(j)) begin
        r_map = 1'b1;
        rdat  = bus.s_rd_data_i[j*DATA_W +: DATA_W];
      end
    rdo = '0;
    if (rd_req_g) rdo[gidx*DATA_W +: DATA_W] = rdat;
    w_err = wr_req_g & wr_en_g & ~w_map;
    r_err = rd_req_g & ~r_map;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= '0;
      owner_valid <= 1'b0;
      rr_ptr      <= '0;
      lock_cnt    <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      owner_valid <= gvld;
      if (gvld) owner <= gidx;
      if (keep) begin
        if (lock_ok) lock_cnt <= lock_cnt + LW'(1);
      end else begin
        lock_cnt <= '0;
      end
      if (gvld && !keep)
        rr_ptr <= (int'(gidx) == NUM_M - 1) ? '0 : gidx + IW'(1);
      err_q <= w_err | r_err;
      if (w_err)      err_addr_q <= wa;
      else if (r_err) err_addr_q <= ra;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.m_hold_o    = req & ~gnt;
  assign bus.s_wr_en_o   = wen;
  assign bus.s_wr_addr_o = wa;
  assign bus.s_wr_data_o = wd;
  assign bus.s_rd_addr_o = ra;
  assign bus.m_rd_data_o = rdo;
  assign bus.err_o       = err_q;
  assign bus.err_addr_o  = err_addr_q;
endmodule
